// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} rf_state_e;
  localparam int RF_MAX_RD = 4;
  function automatic int rf_aw(int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port, registered array read with optional second stage.
// Write-first collision handling is enabled by REGFILE_BYPASS_EN.
module regfile_rd_port import regfile_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int RD_LAT   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            wr_acc_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0] data_o
);
  logic            hit;
  logic [XLEN-1:0] s1_d, s1_q;
`ifdef REGFILE_BYPASS_EN
  assign hit = wr_acc_i && wr_addr_i == addr_i;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_acc_i, wr_addr_i, wr_data_i};
  assign hit = 1'b0;
`endif
  assign s1_d = (clear_i || (ZERO_REG != 0 && addr_i == '0)) ? '0 : hit ? wr_data_i : mem_data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1_q <= '0;
    else s1_q <= s1_d;
  if (RD_LAT == 2) begin : g_s2
    logic [XLEN-1:0] s2_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s2_q <= '0;
      else s2_q <= clear_i ? '0 : s1_q;
    assign data_o = s2_q;
  end else begin : g_s1
    assign data_o = s1_q;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / 1-write register file with a hardware clear sweep.
// Define REGFILE_BYPASS_EN for write-first same-edge collisions (read-first otherwise).
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int RD_LAT   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_req,
  output logic                        busy,
  input  logic [NRD*rf_aw(NREGS)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]         rd_data,
  input  logic                        wr_en,
  input  logic [rf_aw(NREGS)-1:0]     wr_addr,
  input  logic [XLEN-1:0]             wr_data
);
  localparam int AW = rf_aw(NREGS);
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("regfile_mp: RD_LAT must be 1 or 2");
  end
  if (NRD < 1 || NRD > RF_MAX_RD) begin : g_bad_nrd
    $error("regfile_mp: NRD must be 1..4");
  end
  rf_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic            clear, wr_acc;
  assign clear  = state_q == CLEAR;
  assign wr_acc = wr_en && !clear && !(ZERO_REG != 0 && wr_addr == '0);
  assign busy   = busy_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (clear) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = RUN;
        busy_d  = 1'b0;
      end
    end else if (clr_req) begin
      state_d = CLEAR;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  // The array has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk)
    if (clear) mem_q[cnt_q] <= '0;
    else if (wr_acc) mem_q[wr_addr] <= wr_data;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN), .AW(AW), .RD_LAT(RD_LAT), .ZERO_REG(ZERO_REG)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (clear),
      .addr_i    (rd_addr[i*AW +: AW]),
      .mem_data_i(mem_q[rd_addr[i*AW +: AW]]),
      .wr_acc_i  (wr_acc),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .data_o    (rd_data[i*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_regfile_mp;
  localparam int NREGS = 32;
  logic        clk = 0;
  logic        rst_n, clr_req, wr_en, busy;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  int pass_n = 0, tot_n = 0;
  bit chk_en = 0;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: sweep_left counts edges until the clear sweep ends; res1/res2 hold the
  // read result of the previous and current edge (data appears RD_LAT=2 edges on).
  logic [31:0] m_mem [NREGS];
  logic [31:0] res1 [2], res2 [2];
  int sweep_left;

  function automatic logic [31:0] rd_val(input logic [4:0] a);
    if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && sweep_left == 0 && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sweep_left <= NREGS;
      for (int p = 0; p < 2; p++) begin
        res1[p] <= 0;
        res2[p] <= 0;
      end
      for (int i = 0; i < NREGS; i++) m_mem[i] <= 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        res1[p] <= sweep_left > 0 ? 32'h0 : rd_val(rd_addr[p*5 +: 5]);
        res2[p] <= sweep_left > 0 ? 32'h0 : res1[p];
      end
      if (sweep_left > 0) sweep_left <= sweep_left - 1;
      else begin
        if (wr_en && wr_addr != 0) m_mem[wr_addr] <= wr_data;
        if (clr_req) begin
          sweep_left <= NREGS;
          for (int i = 0; i < NREGS; i++) m_mem[i] <= 0;
        end
      end
    end

  always @(negedge clk)
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, sweep_left > 0});
      check("rd0", rd_data[31:0], res2[0]);
      check("rd1", rd_data[63:32], res2[1]);
    end

  task automatic cyc(input logic c, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] a0, input logic [4:0] a1);
    clr_req = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = {a1, a0};
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    cyc(0, 0, 0, 0, a0, a1);
  endtask

  task automatic count_busy(input string name, input int exp);
    int n = 0;
    while (busy && n < 100) begin
      cyc(0, 1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      n++;
    end
    check(name, n, exp);
  endtask

  task automatic all_zero(input string name);
    logic [31:0] acc = 0;
    for (int a = 0; a < NREGS; a++) begin
      idle(5'(a), 5'(NREGS - 1 - a));
      idle(5'(a), 5'(NREGS - 1 - a));
      acc |= rd_data[31:0] | rd_data[63:32];
    end
    check(name, acc, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    clr_req = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    @(negedge clk); #1;
    idle(0, 0);
    idle(0, 0);
    rst_n = 1;
    chk_en = 1;
    // Reset sweep then all registers read zero
    count_busy("reset_busy_cycles", 32);
    all_zero("reset_all_zero");
    // Write then read on both ports
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0);
    idle(0, 0);
    idle(5, 5);
    idle(5, 5);
    check("x5_p0", rd_data[31:0], 32'hDEADBEEF);
    check("x5_p1", rd_data[63:32], 32'hDEADBEEF);
    // Same-edge write/read collision
    cyc(0, 1, 7, 32'h1, 0, 0);
    cyc(0, 1, 7, 32'h12345678, 7, 7);
    idle(7, 7);
`ifdef REGFILE_BYPASS_EN
    check("coll_first", rd_data[31:0], 32'h12345678);
`else
    check("coll_first", rd_data[31:0], 32'h1);
`endif
    idle(7, 7);
    check("coll_next", rd_data[63:32], 32'h12345678);
    // Register zero
    cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0);
    idle(0, 0);
    check("x0_same_edge", rd_data[31:0] | rd_data[63:32], 0);
    idle(0, 0);
    check("x0_after", rd_data[31:0] | rd_data[63:32], 0);
    // Fill then clear sweep, writes ignored while busy
    for (int i = 1; i < NREGS; i++) cyc(0, 1, 5'(i), 32'hA5000000 | i, 0, 0);
    idle(3, 31);
    idle(3, 31);
    check("filled_x3", rd_data[31:0], 32'hA5000003);
    cyc(1, 1, 9, 32'h99, 0, 0);
    count_busy("clr_busy_cycles", 32);
    all_zero("clr_all_zero");
    // Reset in the middle of a sweep
    for (int i = 1; i < NREGS; i++) cyc(0, 1, 5'(i), $urandom | 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) idle(4, 4);
    rst_n = 0;
    #1;
    check("rst_mid_rd", rd_data[31:0] | rd_data[63:32], 0);
    check("rst_mid_busy", {31'b0, busy}, 1);
    idle(4, 4);
    rst_n = 1;
    count_busy("rst_mid_busy_cycles", 32);
    all_zero("rst_mid_all_zero");
    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        idle(0, 0);
        rst_n = 1;
      end else
        cyc($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
